player_cmd_sequencer: RTL and testbench

- Sits directly upstream of the Player block and drives its 16-bit instruction bus.
- Player applies stat opcodes on every clk edge while they are present, so each stat command must appear for exactly one clk cycle.
- Player samples move opcodes only on the clk_10hz edge, so each move command must be held until that edge has passed.
- This block queues stat requests from game logic and latches keyboard moves, then serialises both onto that bus under those timing rules.

---
 rtl/game_isa_pkg.sv | 51 +++++
 rtl/cmd_fifo.sv | 67 ++++++
 rtl/player_cmd_sequencer.sv | 106 ++++++++++
 tb/tb_player_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_isa_pkg.sv
// Shared ISA definitions for the Player instruction bus: opcodes, directions,
// field positions, and the sequencer state encoding.
package game_isa_pkg;

  localparam logic [3:0] OP_NOP     = 4'd0;
  localparam logic [3:0] OP_HEAL    = 4'd1;
  localparam logic [3:0] OP_DMG     = 4'd2;
  localparam logic [3:0] OP_ATK_ADD = 4'd3;
  localparam logic [3:0] OP_ATK_SET = 4'd4;
  localparam logic [3:0] OP_MOVE    = 4'd5;
  localparam logic [3:0] OP_HP_SET  = 4'd6;

  localparam logic [1:0] DIR_UP    = 2'd0;
  localparam logic [1:0] DIR_LEFT  = 2'd1;
  localparam logic [1:0] DIR_DOWN  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int ARG_MSB = 11;
  localparam int ARG_LSB = 4;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_STAT      = 2'd1,
    ST_MOVE_HOLD = 2'd2
  } state_e;

  function automatic logic is_legal_stat(input logic [3:0] op);
    return (op == OP_HEAL) || (op == OP_DMG) || (op == OP_ATK_ADD) ||
           (op == OP_ATK_SET) || (op == OP_HP_SET);
  endfunction

  function automatic logic [15:0] stat_word(input logic [3:0] op, input logic [7:0] arg);
    logic [15:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]   = op;
    w[ARG_MSB:ARG_LSB] = arg;
    return w;
  endfunction

  // The direction occupies the two low bits of the argument field.
  function automatic logic [15:0] move_word(input logic [1:0] dir);
    logic [15:0] w;
    w = '0;
    w[OP_MSB:OP_LSB]        = OP_MOVE;
    w[ARG_LSB+1:ARG_LSB]    = dir;
    return w;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous FIFO holding queued stat commands as {op, arg} words.
// Pushes when full and pops when empty are ignored.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/player_cmd_sequencer.sv
// Serialises queued stat commands and latched keyboard moves onto the Player
// instruction bus: stats for one clk cycle, moves held until a 10 Hz tick.
module player_cmd_sequencer
  import game_isa_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_10hz,
  input  logic             move_valid,
  input  logic [1:0]       move_dir,
  input  logic             stat_valid,
  input  logic [3:0]       stat_op,
  input  logic [7:0]       stat_arg,
  output logic             stat_ready,
  output logic [15:0]      instruction,
  output logic             busy,
  output logic [CNT_W-1:0] fifo_count
);

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic        pend_q, pend_d;
  logic [1:0]  pend_dir_q, pend_dir_d;

  logic        advance;
  logic        fifo_push, fifo_pop;
  logic        fifo_full, fifo_empty;
  logic [11:0] fifo_rdata;

  // Illegal opcodes are still handshaked so the source is never stalled by them.
  assign stat_ready = !fifo_full;
  assign fifo_push  = stat_valid && stat_ready && is_legal_stat(stat_op);

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (12),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .wdata ({stat_op, stat_arg}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A held move may only be replaced once the Player has sampled it on the tick.
  assign advance = (state_q != ST_MOVE_HOLD) || tick_10hz;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      instr_q    <= 16'h0000;
      pend_q     <= 1'b0;
      pend_dir_q <= DIR_UP;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      pend_q     <= pend_d;
      pend_dir_q <= pend_dir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (advance) begin
      if (!fifo_empty)  state_d = ST_STAT;
      else if (pend_q)  state_d = ST_MOVE_HOLD;
      else              state_d = ST_IDLE;
    end
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    instr_d    = instr_q;
    fifo_pop   = 1'b0;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    if (advance) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        instr_d  = stat_word(fifo_rdata[11:8], fifo_rdata[7:0]);
      end else if (pend_q) begin
        instr_d = move_word(pend_dir_q);
        pend_d  = 1'b0;
      end else begin
        instr_d = stat_word(OP_NOP, 8'h00);
      end
    end
    // A fresh request in the issuing cycle is a new move, so it overrides the clear.
    if (move_valid && (state_q != ST_MOVE_HOLD)) begin
      pend_d     = 1'b1;
      pend_dir_d = move_dir;
    end
  end

  assign instruction = instr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_player_cmd_sequencer.sv
// Self-checking bench for player_cmd_sequencer: table of single stat commands
// plus hand sequences for back-to-back, move hold, priority, full FIFO, reset.
module tb_player_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        tick_10hz;
  logic        move_valid;
  logic [1:0]  move_dir;
  logic        stat_valid;
  logic [3:0]  stat_op;
  logic [7:0]  stat_arg;
  logic        stat_ready;
  logic [15:0] instruction;
  logic        busy;
  logic [2:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] sb[$];
  logic [15:0] prev_instr = 16'h0000;

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  arg;
    logic        legal;
    logic [15:0] word;
  } vec_t;

  vec_t vecs[9];

  player_cmd_sequencer #(.FIFO_DEPTH(4), .CNT_W(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .tick_10hz   (tick_10hz),
    .move_valid  (move_valid),
    .move_dir    (move_dir),
    .stat_valid  (stat_valid),
    .stat_op     (stat_op),
    .stat_arg    (stat_arg),
    .stat_ready  (stat_ready),
    .instruction (instruction),
    .busy        (busy),
    .fifo_count  (fifo_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: a new non-NOP word (or any stat word, each lasting one cycle) is one issue.
  task automatic sample();
    if (reset) begin
      prev_instr = 16'h0000;
    end else begin
      if (instruction != 16'h0000 &&
          (instruction != prev_instr || instruction[15:12] != 4'h5)) begin
        if (sb.size() == 0) check("unexpected_issue", {16'h0, instruction}, 32'h0);
        else                check("issue_order", {16'h0, instruction}, {16'h0, sb.pop_front()});
      end
      prev_instr = instruction;
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    sample();
  endtask

  task automatic send_stat(input logic [3:0] op, input logic [7:0] arg,
                           input logic legal, input logic [15:0] word);
    logic ok;
    ok = 1'b0;
    stat_valid = 1'b1;
    stat_op    = op;
    stat_arg   = arg;
    for (int i = 0; i < 64 && !ok; i++) begin
      ok = stat_ready;
      if (ok && legal) sb.push_back(word);
      step();
    end
    stat_valid = 1'b0;
    check("stat_accept", {31'h0, ok}, 32'h1);
  endtask

  task automatic start_move(input logic [1:0] dir, input logic [15:0] word);
    move_valid = 1'b1;
    move_dir   = dir;
    sb.push_back(word);
    step();
    move_valid = 1'b0;
    step();
    check("move_loaded", {16'h0, instruction}, {16'h0, word});
  endtask

  task automatic pulse_tick();
    tick_10hz = 1'b1;
    step();
    tick_10hz = 1'b0;
  endtask

  initial begin
    int bad;
    vecs[0] = '{4'd1,  8'h05, 1'b1, 16'h1050};
    vecs[1] = '{4'd2,  8'hff, 1'b1, 16'h2ff0};
    vecs[2] = '{4'd3,  8'h7a, 1'b1, 16'h37a0};
    vecs[3] = '{4'd4,  8'h00, 1'b1, 16'h4000};
    vecs[4] = '{4'd6,  8'h80, 1'b1, 16'h6800};
    vecs[5] = '{4'd0,  8'h12, 1'b0, 16'h0000};
    vecs[6] = '{4'd5,  8'h34, 1'b0, 16'h0000};
    vecs[7] = '{4'd7,  8'h56, 1'b0, 16'h0000};
    vecs[8] = '{4'd15, 8'h9c, 1'b0, 16'h0000};

    reset = 1'b1; tick_10hz = 1'b0; move_valid = 1'b0; move_dir = 2'd0;
    stat_valid = 1'b0; stat_op = 4'd0; stat_arg = 8'd0;
    repeat (3) step();
    check("reset_instr", {16'h0, instruction}, 32'h0);
    check("reset_count", {29'h0, fifo_count}, 32'h0);
    check("reset_ready", {31'h0, stat_ready}, 32'h1);
    check("reset_busy",  {31'h0, busy}, 32'h0);
    reset = 1'b0;
    step();

    // Single stats; tick held high to show it has no effect outside MOVE_HOLD.
    tick_10hz = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send_stat(vecs[i].op, vecs[i].arg, vecs[i].legal, vecs[i].word);
      check("vec_count",  {29'h0, fifo_count}, {31'h0, vecs[i].legal});
      check("vec_pre",    {16'h0, instruction}, 32'h0);
      step();
      check("vec_word",   {16'h0, instruction}, {16'h0, vecs[i].word});
      check("vec_busy",   {31'h0, busy}, {31'h0, vecs[i].legal});
      step();
      check("vec_post",   {16'h0, instruction}, 32'h0);
      check("vec_drain",  {29'h0, fifo_count}, 32'h0);
    end
    tick_10hz = 1'b0;
    step();

    // Back-to-back stats with no NOP gaps.
    send_stat(4'd2, 8'd3, 1'b1, 16'h2030);
    send_stat(4'd4, 8'd20, 1'b1, 16'h4140);
    check("b2b_0", {16'h0, instruction}, 32'h2030);
    send_stat(4'd6, 8'd50, 1'b1, 16'h6320);
    check("b2b_1", {16'h0, instruction}, 32'h4140);
    step();
    check("b2b_2", {16'h0, instruction}, 32'h6320);
    step();
    check("b2b_nop", {16'h0, instruction}, 32'h0);
    step();

    // Move hold for 50 cycles without a tick, then release.
    start_move(2'd1, 16'h5010);
    check("hold_busy", {31'h0, busy}, 32'h1);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (instruction != 16'h5010) bad++;
    end
    check("hold_50", bad, 32'h0);
    pulse_tick();
    check("hold_exit", {16'h0, instruction}, 32'h0);
    check("hold_exit_busy", {31'h0, busy}, 32'h0);
    step();

    // Pending move and queued heal arrive together: heal goes first.
    move_valid = 1'b1;
    move_dir   = 2'd3;
    send_stat(4'd1, 8'h22, 1'b1, 16'h1220);
    move_valid = 1'b0;
    sb.push_back(16'h5030);
    check("prio_pre", {16'h0, instruction}, 32'h0);
    step();
    check("prio_heal", {16'h0, instruction}, 32'h1220);
    step();
    check("prio_move", {16'h0, instruction}, 32'h5030);
    pulse_tick();
    check("prio_exit", {16'h0, instruction}, 32'h0);
    step();

    // Fill the FIFO during a hold, then drain it back-to-back after the tick.
    start_move(2'd2, 16'h5020);
    send_stat(4'd1, 8'h11, 1'b1, 16'h1110);
    send_stat(4'd2, 8'h22, 1'b1, 16'h2220);
    send_stat(4'd3, 8'h33, 1'b1, 16'h3330);
    send_stat(4'd6, 8'h44, 1'b1, 16'h6440);
    check("full_count", {29'h0, fifo_count}, 32'h4);
    check("full_ready", {31'h0, stat_ready}, 32'h0);
    check("full_held",  {16'h0, instruction}, 32'h5020);
    stat_valid = 1'b1; stat_op = 4'd1; stat_arg = 8'hee;
    repeat (3) step();
    stat_valid = 1'b0;
    check("full_no_push", {29'h0, fifo_count}, 32'h4);
    pulse_tick();
    check("drain_0", {16'h0, instruction}, 32'h1110);
    step();
    check("drain_1", {16'h0, instruction}, 32'h2220);
    step();
    check("drain_2", {16'h0, instruction}, 32'h3330);
    step();
    check("drain_3", {16'h0, instruction}, 32'h6440);
    step();
    check("drain_nop", {16'h0, instruction}, 32'h0);
    check("drain_count", {29'h0, fifo_count}, 32'h0);
    step();

    // Reset in the middle of a hold with a stat queued.
    start_move(2'd0, 16'h5000);
    send_stat(4'd2, 8'h99, 1'b1, 16'h2990);
    check("pre_reset_count", {29'h0, fifo_count}, 32'h1);
    reset = 1'b1;
    sb.delete();
    step();
    check("mid_reset_instr", {16'h0, instruction}, 32'h0);
    check("mid_reset_count", {29'h0, fifo_count}, 32'h0);
    check("mid_reset_busy",  {31'h0, busy}, 32'h0);
    check("mid_reset_ready", {31'h0, stat_ready}, 32'h1);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (instruction != 16'h0000 || busy) bad++;
    end
    check("no_reissue", bad, 32'h0);
    check("scoreboard_drained", sb.size(), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
